// File: rtl/bb_bus_arbiter_if.sv
// Bus-side signal bundle between the bb bus arbiter and the master/slave ports it serves.
// The master modport is the arbiter's view; the slave modport is the requester/slave view.
interface bb_bus_arbiter_if #(
  parameter int NUM_MASTERS = 2,
  parameter int NUM_SLAVES  = 3
);
  localparam int MW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int SW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  logic [NUM_MASTERS-1:0] breq;
  logic [NUM_MASTERS-1:0] bgrant;
  logic [MW-1:0]          msel;
  logic                   bus_busy;
  logic [NUM_MASTERS-1:0] split;
  logic                   slave_split;
  logic [SW-1:0]          ssel;
  logic [NUM_SLAVES-1:0]  split_done;
  logic                   hold_timeout;

  modport master (
    input  breq, slave_split, ssel, split_done,
    output bgrant, msel, bus_busy, split, hold_timeout
  );

  modport slave (
    output breq, slave_split, ssel, split_done,
    input  bgrant, msel, bus_busy, split, hold_timeout
  );
endinterface

// File: rtl/bb_bus_arbiter.sv
// Central arbiter for the bit-serial bb system bus: round-robin grants, split-transaction
// parking with priority resume, and a hold watchdog. All outputs are registered.
module bb_bus_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int NUM_SLAVES  = 3,
  parameter int MAX_HOLD    = 256
) (
  input logic              clk,
  input logic              rstn,
  bb_bus_arbiter_if.master bus
);

  localparam int MW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int SW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int HW = $clog2(MAX_HOLD) + 1;
  localparam logic [NUM_MASTERS-1:0] ONE_HOT0 = NUM_MASTERS'(1);
  localparam logic [HW-1:0]          HOLD_LAST = HW'(MAX_HOLD - 1);

  typedef enum logic [0:0] {IDLE, BUSY} state_t;

  state_t                 state;
  logic [NUM_MASTERS-1:0] split_pending;
  logic [NUM_MASTERS-1:0] resume;
  logic [SW-1:0]          split_slave [NUM_MASTERS];
  logic [MW-1:0]          rr_ptr;
  logic [HW-1:0]          hold_cnt;

  logic [NUM_MASTERS-1:0] eligible;
  logic                   win_found;
  logic                   win_resume;
  logic [MW-1:0]          win_idx;
  logic [MW-1:0]          cand;
  int                     idx;

  // Resume-flagged masters win first (lowest index); otherwise round-robin from rr_ptr+1.
  // Loops run in reverse so the last assignment is the highest-priority candidate.
  always_comb begin
    eligible   = bus.breq & ~split_pending;
    win_found  = 1'b0;
    win_resume = 1'b0;
    win_idx    = '0;
    cand       = '0;
    idx        = 0;
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      if (resume[i]) begin
        win_found  = 1'b1;
        win_resume = 1'b1;
        win_idx    = MW'(i);
      end
    end
    if (!win_resume) begin
      for (int i = NUM_MASTERS; i >= 1; i--) begin
        idx = int'(rr_ptr) + i;
        if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
        cand = MW'(idx);
        if (eligible[cand]) begin
          win_found = 1'b1;
          win_idx   = cand;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state            <= IDLE;
      bus.bgrant       <= '0;
      bus.msel         <= '0;
      bus.bus_busy     <= 1'b0;
      bus.split        <= '0;
      bus.hold_timeout <= 1'b0;
      split_pending    <= '0;
      resume           <= '0;
      rr_ptr           <= MW'(NUM_MASTERS - 1);
      hold_cnt         <= '0;
      for (int m = 0; m < NUM_MASTERS; m++) split_slave[m] <= '0;
    end else begin
      bus.hold_timeout <= 1'b0;

      // Completion only wakes masters that were already parked before this cycle.
      for (int m = 0; m < NUM_MASTERS; m++) begin
        for (int s = 0; s < NUM_SLAVES; s++) begin
          if (split_pending[m] && bus.split_done[s] && (split_slave[m] == SW'(s))) begin
            split_pending[m] <= 1'b0;
            resume[m]        <= 1'b1;
          end
        end
      end

      case (state)
        IDLE: begin
          if (win_found) begin
            bus.bgrant   <= ONE_HOT0 << win_idx;
            bus.msel     <= win_idx;
            bus.bus_busy <= 1'b1;
            rr_ptr       <= win_idx;
            hold_cnt     <= '0;
            state        <= BUSY;
            if (win_resume) begin
              resume[win_idx]    <= 1'b0;
              bus.split[win_idx] <= 1'b0;
            end
          end
        end

        BUSY: begin
          if (bus.slave_split) begin
            split_pending[bus.msel] <= 1'b1;
            split_slave[bus.msel]   <= bus.ssel;
            bus.split[bus.msel]     <= 1'b1;
            bus.bgrant              <= '0;
            bus.bus_busy            <= 1'b0;
            state                   <= IDLE;
          end else if ((hold_cnt == HOLD_LAST) && bus.breq[bus.msel]) begin
            bus.bgrant       <= '0;
            bus.bus_busy     <= 1'b0;
            bus.hold_timeout <= 1'b1;
            state            <= IDLE;
          end else if (!bus.breq[bus.msel]) begin
            bus.bgrant   <= '0;
            bus.bus_busy <= 1'b0;
            state        <= IDLE;
          end else if (hold_cnt != {HW{1'b1}}) begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bb_bus_arbiter.sv
// Directed self-checking bench for bb_bus_arbiter (2 masters, 3 slaves, MAX_HOLD=8).
module tb_bb_bus_arbiter;

  logic clk;
  logic rstn;
  int   checks;
  int   errors;

  bb_bus_arbiter_if #(.NUM_MASTERS(2), .NUM_SLAVES(3)) bus ();

  bb_bus_arbiter #(
    .NUM_MASTERS(2),
    .NUM_SLAVES (3),
    .MAX_HOLD   (8)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] breq, input logic slave_split,
                               input logic [1:0] ssel, input logic [2:0] split_done);
    bus.breq        = breq;
    bus.slave_split = slave_split;
    bus.ssel        = ssel;
    bus.split_done  = split_done;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic doReset();
    applyStimulus(2'b00, 1'b0, 2'd0, 3'b000);
    rstn = 1'b0;
    step(2);
    rstn = 1'b1;
    step(1);
  endtask

  initial begin
    logic [1:0] exp_g;
    checks = 0;
    errors = 0;
    rstn   = 1'b0;
    applyStimulus(2'b00, 1'b0, 2'd0, 3'b000);
    #2;
    checkOutput("rst_bgrant", 32'(bus.bgrant), 32'h0);
    checkOutput("rst_msel", 32'(bus.msel), 32'h0);
    checkOutput("rst_busy", 32'(bus.bus_busy), 32'h0);
    checkOutput("rst_split", 32'(bus.split), 32'h0);
    checkOutput("rst_timeout", 32'(bus.hold_timeout), 32'h0);
    step(2);
    rstn = 1'b1;
    step(1);

    $display("[TB] single request");
    applyStimulus(2'b01, 1'b0, 2'd0, 3'b000);
    step(1);
    checkOutput("t1_grant", 32'(bus.bgrant), 32'h1);
    checkOutput("t1_msel", 32'(bus.msel), 32'h0);
    checkOutput("t1_busy", 32'(bus.bus_busy), 32'h1);
    step(3);
    checkOutput("t1_hold", 32'(bus.bgrant), 32'h1);
    applyStimulus(2'b00, 1'b0, 2'd0, 3'b000);
    step(1);
    checkOutput("t1_release", 32'(bus.bgrant), 32'h0);
    checkOutput("t1_idle_busy", 32'(bus.bus_busy), 32'h0);

    $display("[TB] round robin");
    doReset();
    applyStimulus(2'b11, 1'b0, 2'd0, 3'b000);
    step(1);
    for (int k = 0; k < 4; k++) begin
      exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
      checkOutput("t2_grant", 32'(bus.bgrant), 32'(exp_g));
      checkOutput("t2_msel", 32'(bus.msel), 32'(k % 2));
      step(4);
      checkOutput("t2_held", 32'(bus.bgrant), 32'(exp_g));
      applyStimulus(2'b11 & ~exp_g, 1'b0, 2'd0, 3'b000);
      step(1);
      checkOutput("t2_gap", 32'(bus.bgrant), 32'h0);
      checkOutput("t2_msel_hold", 32'(bus.msel), 32'(k % 2));
      applyStimulus(2'b11, 1'b0, 2'd0, 3'b000);
      step(1);
    end
    applyStimulus(2'b00, 1'b0, 2'd0, 3'b000);
    step(2);

    $display("[TB] split and resume");
    doReset();
    applyStimulus(2'b11, 1'b0, 2'd0, 3'b000);
    step(1);
    checkOutput("t3_m0_grant", 32'(bus.bgrant), 32'h1);
    applyStimulus(2'b11, 1'b1, 2'd2, 3'b000);
    step(1);
    checkOutput("t3_split", 32'(bus.split), 32'h1);
    checkOutput("t3_freed", 32'(bus.bgrant), 32'h0);
    applyStimulus(2'b11, 1'b0, 2'd0, 3'b000);
    step(1);
    checkOutput("t3_m1_grant", 32'(bus.bgrant), 32'h2);
    checkOutput("t3_m1_msel", 32'(bus.msel), 32'h1);
    step(1);
    applyStimulus(2'b11, 1'b0, 2'd0, 3'b100);
    step(1);
    checkOutput("t3_done_split", 32'(bus.split), 32'h1);
    checkOutput("t3_done_grant", 32'(bus.bgrant), 32'h2);
    applyStimulus(2'b11, 1'b0, 2'd0, 3'b000);
    step(1);
    checkOutput("t3_still_m1", 32'(bus.bgrant), 32'h2);
    applyStimulus(2'b01, 1'b0, 2'd0, 3'b000);
    step(1);
    checkOutput("t3_m1_rel", 32'(bus.bgrant), 32'h0);
    checkOutput("t3_split_wait", 32'(bus.split), 32'h1);
    applyStimulus(2'b11, 1'b0, 2'd0, 3'b000);
    step(1);
    checkOutput("t3_resume", 32'(bus.bgrant), 32'h1);
    checkOutput("t3_split_clr", 32'(bus.split), 32'h0);
    applyStimulus(2'b00, 1'b0, 2'd0, 3'b000);
    step(2);

    $display("[TB] watchdog");
    doReset();
    applyStimulus(2'b10, 1'b0, 2'd0, 3'b000);
    step(1);
    checkOutput("t4_m1_grant", 32'(bus.bgrant), 32'h2);
    applyStimulus(2'b11, 1'b0, 2'd0, 3'b000);
    for (int i = 1; i < 8; i++) begin
      step(1);
      checkOutput("t4_hold", 32'(bus.bgrant), 32'h2);
      checkOutput("t4_no_to", 32'(bus.hold_timeout), 32'h0);
    end
    step(1);
    checkOutput("t4_revoked", 32'(bus.bgrant), 32'h0);
    checkOutput("t4_timeout", 32'(bus.hold_timeout), 32'h1);
    step(1);
    checkOutput("t4_m0_grant", 32'(bus.bgrant), 32'h1);
    checkOutput("t4_to_pulse", 32'(bus.hold_timeout), 32'h0);
    applyStimulus(2'b01, 1'b0, 2'd0, 3'b000);
    step(2);
    checkOutput("t4_m0_keeps", 32'(bus.bgrant), 32'h1);
    applyStimulus(2'b00, 1'b0, 2'd0, 3'b000);
    step(2);

    $display("[TB] reset mid-split");
    doReset();
    applyStimulus(2'b01, 1'b0, 2'd0, 3'b000);
    step(1);
    applyStimulus(2'b01, 1'b1, 2'd2, 3'b000);
    step(1);
    checkOutput("t5_split", 32'(bus.split), 32'h1);
    applyStimulus(2'b10, 1'b0, 2'd0, 3'b000);
    step(1);
    checkOutput("t5_m1_grant", 32'(bus.bgrant), 32'h2);
    #1 rstn = 1'b0;
    #1;
    checkOutput("t5_rst_grant", 32'(bus.bgrant), 32'h0);
    checkOutput("t5_rst_split", 32'(bus.split), 32'h0);
    checkOutput("t5_rst_msel", 32'(bus.msel), 32'h0);
    checkOutput("t5_rst_busy", 32'(bus.bus_busy), 32'h0);
    #1 rstn = 1'b1;
    applyStimulus(2'b00, 1'b0, 2'd0, 3'b100);
    step(1);
    applyStimulus(2'b00, 1'b0, 2'd0, 3'b000);
    step(2);
    checkOutput("t5_after_split", 32'(bus.split), 32'h0);
    checkOutput("t5_after_grant", 32'(bus.bgrant), 32'h0);

    $display("[TB] stray split_done");
    doReset();
    applyStimulus(2'b01, 1'b0, 2'd0, 3'b000);
    step(1);
    applyStimulus(2'b01, 1'b0, 2'd0, 3'b010);
    step(1);
    checkOutput("t6_grant", 32'(bus.bgrant), 32'h1);
    checkOutput("t6_split", 32'(bus.split), 32'h0);
    checkOutput("t6_timeout", 32'(bus.hold_timeout), 32'h0);
    applyStimulus(2'b01, 1'b0, 2'd0, 3'b000);
    step(1);
    checkOutput("t6_grant2", 32'(bus.bgrant), 32'h1);
    checkOutput("t6_msel", 32'(bus.msel), 32'h0);

    $display("[TB] wrong-slave completion");
    applyStimulus(2'b01, 1'b1, 2'd1, 3'b000);
    step(1);
    checkOutput("t7_split", 32'(bus.split), 32'h1);
    applyStimulus(2'b01, 1'b0, 2'd0, 3'b100);
    step(1);
    applyStimulus(2'b01, 1'b0, 2'd0, 3'b000);
    step(2);
    checkOutput("t7_parked", 32'(bus.bgrant), 32'h0);
    checkOutput("t7_split_kept", 32'(bus.split), 32'h1);
    applyStimulus(2'b01, 1'b0, 2'd0, 3'b010);
    step(1);
    checkOutput("t7_not_yet", 32'(bus.bgrant), 32'h0);
    applyStimulus(2'b01, 1'b0, 2'd0, 3'b000);
    step(1);
    checkOutput("t7_resume", 32'(bus.bgrant), 32'h1);
    checkOutput("t7_split_clr", 32'(bus.split), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
